// File: rtl/ibex_pkg.sv
// Shared types for the CHERI writeback stage: FSM state, pending-entry record
// and the width of each CHERI exception vector.
package ibex_pkg;

    localparam int unsigned CheriExcWidth = 3;

    typedef enum logic [0:0] {
        WB_IDLE     = 1'b0,
        WB_WAIT_LSU = 1'b1
    } wb_state_e;

    // Instruction accepted from EX; exc_cause is {exc_b, exc_a}
    typedef struct packed {
        logic [4:0]                 waddr;
        logic                       we;
        logic [2*CheriExcWidth-1:0] exc_cause;
    } wb_entry_t;

endpackage

// File: rtl/ibex_cheri_wb_cap_fmt.sv
// Formats writeback data to capability width and masks writes to x0.
// Integer results are zero-extended, which leaves the tag bit clear.
module ibex_cheri_wb_cap_fmt #(
    parameter int unsigned CheriCapWidth = 91
) (
    input  logic                     is_cap,
    input  logic [CheriCapWidth-1:0] cap_data,
    input  logic [31:0]              int_data,
    input  logic [4:0]               waddr,
    input  logic                     we,
    output logic [CheriCapWidth-1:0] wdata,
    output logic                     we_masked
);

    assign wdata     = is_cap ? cap_data : {{(CheriCapWidth-32){1'b0}}, int_data};
    assign we_masked = we & (waddr != 5'd0);

endmodule

// File: rtl/ibex_cheri_wb_stage.sv
// CHERI writeback stage: captures EX results and exception flags, waits for
// LSU responses on loads, and issues one register-file write per retired
// instruction. Optional ID-stage bypass ports are enabled by defining
// IBEX_CHERI_WB_FWD_EN.
module ibex_cheri_wb_stage
    import ibex_pkg::*;
#(
    parameter int unsigned CheriCapWidth = 91,
    parameter int unsigned ExcWidth      = CheriExcWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_wb_i,
    input  logic                     instr_is_load_i,
    input  logic [4:0]               rf_waddr_i,
    input  logic                     rf_we_i,
    input  logic [31:0]              result_ex_i,
    input  logic [CheriCapWidth-1:0] cheri_result_i,
    input  logic                     cheri_wrote_cap_i,
    input  logic [ExcWidth-1:0]      cheri_exc_a_i,
    input  logic [ExcWidth-1:0]      cheri_exc_b_i,
    input  logic                     lsu_resp_valid_i,
    input  logic [CheriCapWidth-1:0] lsu_rdata_i,
    input  logic                     lsu_resp_err_i,
    output logic                     ready_wb_o,
    output logic                     rf_we_o,
    output logic [4:0]               rf_waddr_o,
    output logic [CheriCapWidth-1:0] rf_wdata_o,
    output logic                     cheri_exc_o,
    output logic [2*ExcWidth-1:0]    cheri_exc_cause_o,
`ifdef IBEX_CHERI_WB_FWD_EN
    output logic                     fwd_valid_o,
    output logic [4:0]               fwd_addr_o,
    output logic [CheriCapWidth-1:0] fwd_data_o,
`endif
    output logic                     load_err_o
);

    wb_state_e state_q, state_d;
    wb_entry_t entry_q;

    logic                     accept;
    logic                     exc_now;
    logic                     retire;
    logic                     exc_pulse;
    logic                     err_pulse;
    logic                     fmt_is_cap;
    logic [CheriCapWidth-1:0] fmt_cap;
    logic [4:0]               fmt_waddr;
    logic                     fmt_we;
    logic [CheriCapWidth-1:0] fmt_wdata;
    logic                     fmt_we_masked;

    logic                     rf_we_q;
    logic [4:0]               rf_waddr_q;
    logic [CheriCapWidth-1:0] rf_wdata_q;
    logic                     cheri_exc_q;
    logic                     load_err_q;

    assign exc_now = (|cheri_exc_a_i) | (|cheri_exc_b_i);
    assign accept  = en_wb_i & (state_q == WB_IDLE);

    // State register
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst_i) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: loads without an exception wait for the LSU response
    always_comb begin
        // NOTE: default assignment first so no branch leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            WB_IDLE:     if (accept && instr_is_load_i && !exc_now) state_d = WB_WAIT_LSU;
            WB_WAIT_LSU: if (lsu_resp_valid_i) state_d = WB_IDLE;
            default:     state_d = WB_IDLE;
        endcase
    end

    // Outputs per state: ready, retire strobes and selection of the write source
    always_comb begin
        ready_wb_o = 1'b0;
        retire     = 1'b0;
        exc_pulse  = 1'b0;
        err_pulse  = 1'b0;
        fmt_is_cap = cheri_wrote_cap_i;
        fmt_cap    = cheri_result_i;
        fmt_waddr  = rf_waddr_i;
        fmt_we     = rf_we_i & ~exc_now;
        unique case (state_q)
            WB_IDLE: begin
                ready_wb_o = 1'b1;
                retire     = accept & (~instr_is_load_i | exc_now);
                exc_pulse  = accept & exc_now;
            end
            WB_WAIT_LSU: begin
                fmt_is_cap = 1'b1;
                fmt_cap    = lsu_rdata_i;
                fmt_waddr  = entry_q.waddr;
                fmt_we     = entry_q.we & ~lsu_resp_err_i;
                retire     = lsu_resp_valid_i;
                err_pulse  = lsu_resp_valid_i & lsu_resp_err_i;
            end
            default: ;
        endcase
    end

    ibex_cheri_wb_cap_fmt #(
        .CheriCapWidth(CheriCapWidth)
    ) u_cap_fmt (
        .is_cap    (fmt_is_cap),
        .cap_data  (fmt_cap),
        .int_data  (result_ex_i),
        .waddr     (fmt_waddr),
        .we        (fmt_we),
        .wdata     (fmt_wdata),
        .we_masked (fmt_we_masked)
    );

    // Capture the accepted instruction; its cause stays visible until the next accept
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= '0;
        end else if (accept) begin
            entry_q.waddr     <= rf_waddr_i;
            entry_q.we        <= rf_we_i;
            entry_q.exc_cause <= {cheri_exc_b_i, cheri_exc_a_i};
        end
    end

    // Retire register: one-cycle write/exception/error strobes plus held address and data
    always_ff @(posedge clk_i) begin
        // NOTE: the wide data register is reset as well because the outputs must read 0 out of reset.
        if (rst_i) begin
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            cheri_exc_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            rf_we_q     <= retire & fmt_we_masked;
            cheri_exc_q <= exc_pulse;
            load_err_q  <= err_pulse;
            if (retire) begin
                rf_waddr_q <= fmt_waddr;
                rf_wdata_q <= fmt_wdata;
            end
        end
    end

    assign rf_we_o           = rf_we_q;
    assign rf_waddr_o        = rf_waddr_q;
    assign rf_wdata_o        = rf_wdata_q;
    assign cheri_exc_o       = cheri_exc_q;
    assign load_err_o        = load_err_q;
    assign cheri_exc_cause_o = entry_q.exc_cause;

`ifdef IBEX_CHERI_WB_FWD_EN
    logic fwd_same;
    assign fwd_same = accept & ~instr_is_load_i & ~exc_now;

    // Bypass: same-cycle integer result has priority over the write retiring this cycle
    always_comb begin
        fwd_valid_o = fwd_same | rf_we_q;
        fwd_addr_o  = rf_waddr_q;
        fwd_data_o  = rf_wdata_q;
        if (fwd_same) begin
            fwd_addr_o = rf_waddr_i;
            fwd_data_o = fmt_wdata;
        end
    end
`else
    // No bypass: ID stalls until the write has reached the register file.
`endif

    // ID must not present a result while WB is busy
    a_no_en_when_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        !(en_wb_i && !ready_wb_o));

    // LSU responses are only legal while a load is pending
    a_no_resp_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        !(lsu_resp_valid_i && state_q == WB_IDLE));

endmodule
